mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped serial transmit peripheral that sits directly downstream of the processor top level.
- Snoops the processor's data-memory store bus (memwrite, dataadr, writedata) alongside dmem.
- A store to the TX address queues one byte in a small FIFO; an 8N1 serializer drains the FIFO onto the tx line.
- Gives the core console output without a dmem model change.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2).
- FIFO_DEPTH, 4, byte entries in the transmit FIFO (power of two, >= 2).
- TX_ADDR, 32'hFFFF_FFF0, word address decoded as the TX data register.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  store strobe from the processor.
- dataadr  input  32  store address from the processor.
- writedata  input  32  store data from the processor; only bits [7:0] are used.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overrun_count  output  8  number of dropped stores, saturating.

Behaviour:
- Reset (asynchronous, immediate effect):
  - tx=1, busy=0, fifo_full=0, overrun_count=0.
  - FIFO empty, FSM in IDLE, bit and clock counters 0.
  - A reset mid-frame aborts the frame; tx returns high without waiting for a clock edge.
- Decode:
  - hit = memwrite && (dataadr == TX_ADDR). The full 32 bits are compared; any other address is ignored.
  - On a hit at edge k, writedata[7:0] is pushed at edge k, unless the FIFO is full and no pop occurs at edge k.
- Overrun:
  - A hit while full with no same-edge pop is dropped.
  - overrun_count increments by 1 and saturates at 255; it clears only on reset.
- Simultaneous events:
  - Push and pop on the same edge keep the count unchanged.
  - When full, a same-edge pop frees a slot, so the push is accepted and not counted as an overrun.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Occupancy count width is $clog2(FIFO_DEPTH+1).
  - fifo_full = (count == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear clk_cnt, go to START. A byte pushed at edge k is popped at edge k+1, so tx falls at edge k+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles; then shift right and increment bit_idx. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Timing and outputs:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - clk_cnt counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
  - tx is driven from a register (glitch-free).
  - busy = (state != IDLE) || (count != 0).
- The block never stalls the processor. Stores to TX_ADDR also reach dmem unchanged; this block does not gate memwrite.

Decomposition:
- Package riscy_mmio_pkg holds:
  - the uart_state_t enum {IDLE, START, DATA, STOP};
  - the TX_ADDR default constant (MMIO_UART_TX_ADDR);
  - the OVERRUN_MAX constant (8'hFF).
- One sub-module, byte_fifo, provides the synchronous FIFO.
  - Parameter: DEPTH.
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count.
- mmio_uart_tx instantiates byte_fifo and contains the decode, overrun counter and serializer FSM.

Test Plan:
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: store 32'h0000_0155 to TX_ADDR.
  - Response: tx low from the next edge for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. busy deasserts exactly 40 cycles after tx falls.
- Address decode:
  - Stimulus: stores to TX_ADDR+4 and 32'h0000_0054, and a read cycle (memwrite=0) at TX_ADDR.
  - Response: tx stays 1, busy stays 0, FIFO count stays 0.
- Overrun with FIFO_DEPTH=4, CLKS_PER_BIT=16:
  - Stimulus: 6 consecutive-cycle stores of 0x41..0x46.
  - Response: the first byte is popped one edge after its push, so 0x41..0x45 are accepted and 0x46 is dropped. fifo_full=1 after the 5th store; overrun_count=1. 0x41..0x45 appear on tx back-to-back with no idle gap between frames.
- Saturation:
  - Stimulus: with the FIFO full and no pop pending, 300 further stores to TX_ADDR.
  - Response: overrun_count reaches 255 and holds there.
- Push at pop:
  - Stimulus: a store arrives while full on exactly the final STOP cycle of a frame.
  - Response: the byte is accepted, fifo_full remains 1, overrun_count is unchanged.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 with 2 bytes queued.
  - Response: tx=1 immediately (before the next edge), and busy=0, fifo_full=0, overrun_count=0. After release, no further frames are sent.

Source files
------------

// File: rtl/riscy_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmit peripheral.
package riscy_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [31:0] MMIO_UART_TX_ADDR = 32'hFFFF_FFF0;
    localparam logic [7:0]  OVERRUN_MAX       = 8'hFF;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO; circular buffer with wrapping pointers and an occupancy count.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [7:0]                     din,
    input  logic                           pop,
    output logic [7:0]                     dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // A pop on the same edge frees the slot, so a push into a full FIFO is then legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: address decode, overrun counter and 8N1 serializer.
module mmio_uart_tx
    import riscy_mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = MMIO_UART_TX_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  overrun_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH+1);

    uart_state_t    state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic [7:0]     overrun_q;

    logic           hit;
    logic           push;
    logic           pop;
    logic           drop;
    logic           bit_end;
    logic [7:0]     fifo_dout;
    logic           fifo_full_w;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_wdata;

    assign unused_wdata = ^writedata[31:8];

    assign hit     = memwrite && (dataadr == TX_ADDR);
    assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Pops happen when idle, or on the last stop-bit cycle so frames run back to back.
    assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    assign push = hit && (!fifo_full_w || pop);
    assign drop = hit && fifo_full_w && !pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (writedata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full_w),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (drop && (overrun_q != OVERRUN_MAX)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_dout;
                        clk_cnt_q <= '0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_dout;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx            = tx_q;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);
    assign fifo_full     = fifo_full_w;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-level queue model of the transmitter.
module tb_mmio_uart_tx;
    import riscy_mmio_pkg::*;

    localparam int C = 4;
    localparam int D = 4;
    localparam logic [31:0] A = MMIO_UART_TX_ADDR;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  overrun_count;

    int total = 0;
    int bad = 0;

    // Reference model: a byte queue plus the position inside the frame currently on the line.
    logic [7:0] m_q [$];
    bit         m_in_frame;
    int         m_pos;
    logic [7:0] m_cur;
    int         m_ovr;

    mmio_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D),
        .TX_ADDR      (A)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memwrite      (memwrite),
        .dataadr       (dataadr),
        .writedata     (writedata),
        .tx            (tx),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_q.delete();
        m_in_frame = 0;
        m_pos = 0;
        m_cur = 8'h00;
        m_ovr = 0;
    endfunction

    function automatic void model_edge(input logic mw, input logic [31:0] adr,
                                       input logic [31:0] d);
        bit hit;
        bit pop;
        bit was_full;
        hit = mw && (adr == A);
        was_full = (m_q.size() == D);
        pop = (m_q.size() > 0) && (!m_in_frame || m_pos == 10 * C - 1);
        if (pop) m_cur = m_q.pop_front();
        if (hit) begin
            if (!was_full || pop) m_q.push_back(d[7:0]);
            else if (m_ovr < 255) m_ovr++;
        end
        if (pop) begin
            m_in_frame = 1;
            m_pos = 0;
        end else if (m_in_frame) begin
            m_pos++;
            if (m_pos == 10 * C) m_in_frame = 0;
        end
    endfunction

    function automatic logic exp_tx();
        int b;
        if (!m_in_frame) return 1'b1;
        b = m_pos / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_in_frame || (m_q.size() != 0);
    endfunction

    function automatic logic exp_full();
        return m_q.size() == D;
    endfunction

    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] d);
        @(negedge clk);
        memwrite = mw;
        dataadr = adr;
        writedata = d;
        @(posedge clk);
        model_edge(mw, adr, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        memwrite = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", fifo_full); end
        total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL reset_ovr got=%0d want=0", overrun_count); end
    endtask

    task automatic test_single();
        int cycles;
        do_reset();
        step(1'b1, A, 32'h0000_0155);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_pre_fall got=%b want=1", tx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        step(1'b0, 32'h0, 32'h0);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL single_start got=%b want=0", tx); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            step(1'b0, 32'h0, 32'h0);
            cycles++;
            total++;
            if (tx !== exp_tx()) begin
                bad++; $display("FAIL single_tx cyc=%0d got=%b want=%b", cycles, tx, exp_tx());
            end
        end
        total++; if (cycles != 40) begin bad++; $display("FAIL single_len got=%0d want=40", cycles); end
    endtask

    task automatic test_decode();
        logic [31:0] adrs [4];
        logic        mws [4];
        do_reset();
        adrs[0] = A + 32'd4;  mws[0] = 1'b1;
        adrs[1] = 32'h0000_0054; mws[1] = 1'b1;
        adrs[2] = A;          mws[2] = 1'b0;
        adrs[3] = A ^ (32'd1 << $urandom_range(31)); mws[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(mws[i], adrs[i], $urandom);
            step(1'b0, 32'h0, 32'h0);
            total++; if (tx !== 1'b1) begin bad++; $display("FAIL decode_tx i=%0d got=%b want=1", i, tx); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL decode_busy i=%0d got=%b want=0", i, busy); end
            total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL decode_full i=%0d got=%b want=0", i, fifo_full); end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, A, 32'h41 + i);
            if (i == 4) begin
                total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL ovr_full got=%b want=1", fifo_full); end
            end
        end
        total++; if (overrun_count !== 8'd1) begin bad++; $display("FAIL ovr_count got=%0d want=1", overrun_count); end
        for (int i = 0; i < 5 * 10 * C + 10; i++) begin
            step(1'b0, 32'h0, 32'h0);
            total++;
            if (tx !== exp_tx() || busy !== exp_busy()) begin
                bad++; $display("FAIL ovr_stream cyc=%0d got=%b/%b want=%b/%b", i, tx, busy, exp_tx(), exp_busy());
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", busy); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) step(1'b1, A, $urandom);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, A, $urandom);
            total++;
            if (overrun_count !== 8'(m_ovr) || fifo_full !== exp_full()) begin
                bad++; $display("FAIL sat_step i=%0d got=%0d/%b want=%0d/%b", i, overrun_count, fifo_full, m_ovr, exp_full());
            end
        end
        total++; if (overrun_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", overrun_count); end
    endtask

    task automatic test_push_at_pop();
        int guard;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, A, $urandom);
        guard = 0;
        while (!(m_in_frame && m_pos == 10 * C - 1) && guard < 200) begin
            step(1'b0, 32'h0, 32'h0);
            guard++;
        end
        total++; if (guard >= 200) begin bad++; $display("FAIL pap_timeout got=%0d want<200", guard); end
        step(1'b1, A, $urandom);
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL pap_full got=%b want=1", fifo_full); end
        total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL pap_ovr got=%0d want=0", overrun_count); end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL pap_next_start got=%b want=0", tx); end
        for (int i = 0; i < 4 * 10 * C; i++) begin
            step(1'b0, 32'h0, 32'h0);
            total++;
            if (tx !== exp_tx()) begin bad++; $display("FAIL pap_stream cyc=%0d got=%b want=%b", i, tx, exp_tx()); end
        end
    endtask

    task automatic test_random();
        int rate;
        logic        mw;
        logic [31:0] adr;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            rate = ((i / 150) % 2 == 1) ? 3 : 40;
            mw = ($urandom_range(99) < rate);
            adr = ($urandom_range(9) == 0) ? $urandom : A;
            step(mw, adr, $urandom);
            total++;
            if (tx !== exp_tx() || busy !== exp_busy() || fifo_full !== exp_full()
                || overrun_count !== 8'(m_ovr)) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b%b%b/%0d want=%b%b%b/%0d", i, tx, busy, fifo_full,
                         overrun_count, exp_tx(), exp_busy(), exp_full(), m_ovr);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int guard;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, A, 32'h0000_0000);
        guard = 0;
        while (!(m_in_frame && m_pos == 4 * C + 1) && guard < 100) begin
            step(1'b0, 32'h0, 32'h0);
            guard++;
        end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx got=%b want=0", tx); end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL mid_full got=%b want=0", fifo_full); end
        total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL mid_ovr got=%0d want=0", overrun_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 32'h0, 32'h0);
            total++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_after cyc=%0d got=%b/%b want=1/0", i, tx, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        memwrite = 1'b0;
        dataadr = 32'h0;
        writedata = 32'h0;
        model_clear();
        test_reset();
        test_single();
        test_decode();
        test_overrun();
        test_saturation();
        test_push_at_pop();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
